// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : 640x480@60 timing defaults, axis-total helper, phase encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_t;

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis: position counter plus ACT/FP/SYNC/BP phase FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             sys_rst_n,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic [CNT_W-1:0] next_count,
    output phase_t           next_phase
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] C_LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] C_FP_START   = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] C_SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] C_BP_START   = CNT_W'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] r_count;
    phase_t           r_phase;
    logic [CNT_W-1:0] w_next_count;
    phase_t           w_next_phase;

    assign wrap = advance && (r_count == C_LAST);

    always_comb begin
        w_next_count = r_count;
        if (advance) begin
            w_next_count = wrap ? '0 : r_count + CNT_W'(1);
        end
    end

    // The phase changes on the same edge the counter crosses a boundary.
    always_comb begin
        w_next_phase = r_phase;
        if (advance) begin
            case (r_phase)
                PH_ACT:  if (w_next_count == C_FP_START)   w_next_phase = PH_FP;
                PH_FP:   if (w_next_count == C_SYNC_START) w_next_phase = PH_SYNC;
                PH_SYNC: if (w_next_count == C_BP_START)   w_next_phase = PH_BP;
                PH_BP:   if (wrap)                         w_next_phase = PH_ACT;
                default: w_next_phase = PH_ACT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_count <= '0;
            r_phase <= PH_ACT;
        end else begin
            r_count <= w_next_count;
            r_phase <= w_next_phase;
        end
    end

    assign count      = r_count;
    assign next_count = w_next_count;
    assign next_phase = w_next_phase;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Free-running VGA raster generator with per-frame scroll position.
//               Define VGA_SYNC_DELAY_EN to delay hsync/vsync by one pixel clock.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             sys_rst_n,
    input  logic             scroll_en,
    input  logic [2:0]       scroll_speed,
    output logic [CNT_W-1:0] haddr,
    output logic [CNT_W-1:0] vaddr,
    output logic             display_on,
    output logic             hsync,
    output logic             vsync,
    output logic             line_tick,
    output logic             frame_tick,
    output logic [10:0]      scrolladdr
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_V_LAST = CNT_W'(V_TOTAL - 1);

    logic             w_h_wrap;
    logic             w_v_wrap;
    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    phase_t           w_h_next_phase;
    phase_t           w_v_next_phase;

    logic             r_display_on;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_line_tick;
    logic             r_frame_tick;
    logic [10:0]      r_scroll;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP)
    ) u_h_axis (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .advance    (1'b1),
        .count      (haddr),
        .wrap       (w_h_wrap),
        .next_count (w_h_next),
        .next_phase (w_h_next_phase)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP)
    ) u_v_axis (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .advance    (w_h_wrap),
        .count      (vaddr),
        .wrap       (w_v_wrap),
        .next_count (w_v_next),
        .next_phase (w_v_next_phase)
    );

    // Outputs are decoded from the next-state counters so they line up with haddr/vaddr.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_display_on <= 1'b0;
            r_hsync      <= ~SYNC_POL;
            r_vsync      <= ~SYNC_POL;
            r_line_tick  <= 1'b0;
            r_frame_tick <= 1'b0;
            r_scroll     <= '0;
        end else begin
            r_display_on <= (w_h_next_phase == PH_ACT) && (w_v_next_phase == PH_ACT);
            r_hsync      <= (w_h_next_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_vsync      <= (w_v_next_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_line_tick  <= (w_h_next == C_H_LAST);
            r_frame_tick <= (w_h_next == C_H_LAST) && (w_v_next == C_V_LAST);
            if (w_v_wrap && scroll_en) begin
                r_scroll <= r_scroll + {8'd0, scroll_speed};
            end
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic r_hsync_d;
    logic r_vsync_d;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_hsync_d <= ~SYNC_POL;
            r_vsync_d <= ~SYNC_POL;
        end else begin
            r_hsync_d <= r_hsync;
            r_vsync_d <= r_vsync;
        end
    end

    assign hsync = r_hsync_d;
    assign vsync = r_vsync_d;
`else
    assign hsync = r_hsync;
    assign vsync = r_vsync;
`endif

    assign display_on = r_display_on;
    assign line_tick  = r_line_tick;
    assign frame_tick = r_frame_tick;
    assign scrolladdr = r_scroll;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Bench for vga_timing_gen: full-size and shrunken-raster instances
//               checked every cycle against an arithmetic raster model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int DH_A = 640, DH_F = 16, DH_S = 96, DH_B = 48;
    localparam int DV_A = 480, DV_F = 10, DV_S = 2,  DV_B = 33;
    localparam int SH_A = 4,   SH_F = 1,  SH_S = 2,  SH_B = 1;
    localparam int SV_A = 3,   SV_F = 1,  SV_S = 1,  SV_B = 1;
    localparam int D_FRAME = 800 * 525;
    localparam int S_FRAME = 8 * 6;
`ifdef VGA_SYNC_DELAY_EN
    localparam int SHIFT = 1;
`else
    localparam int SHIFT = 0;
`endif

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        scroll_en;
    logic [2:0]  scroll_speed;

    logic [9:0]  d_haddr, d_vaddr, s_haddr, s_vaddr;
    logic        d_disp, d_hs, d_vs, d_lt, d_ft;
    logic        s_disp, s_hs, s_vs, s_lt, s_ft;
    logic [10:0] d_scroll, s_scroll;

    int n_cmp  = 0;
    int n_fail = 0;

    // model state: pixel clocks since reset release, and scroll accumulators
    int pd = 0, ps = 0, scr_d = 0, scr_s = 0;
    bit rs = 1'b1;

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .clk (clk), .sys_rst_n (sys_rst_n), .scroll_en (scroll_en), .scroll_speed (scroll_speed),
        .haddr (d_haddr), .vaddr (d_vaddr), .display_on (d_disp), .hsync (d_hs), .vsync (d_vs),
        .line_tick (d_lt), .frame_tick (d_ft), .scrolladdr (d_scroll)
    );

    vga_timing_gen #(
        .H_ACTIVE (SH_A), .H_FP (SH_F), .H_SYNC (SH_S), .H_BP (SH_B),
        .V_ACTIVE (SV_A), .V_FP (SV_F), .V_SYNC (SV_S), .V_BP (SV_B), .SYNC_POL (1'b0)
    ) dut_s (
        .clk (clk), .sys_rst_n (sys_rst_n), .scroll_en (scroll_en), .scroll_speed (scroll_speed),
        .haddr (s_haddr), .vaddr (s_vaddr), .display_on (s_disp), .hsync (s_hs), .vsync (s_vs),
        .line_tick (s_lt), .frame_tick (s_ft), .scrolladdr (s_scroll)
    );

    // Expected outputs from raster position p (pixel clocks since release).
    function automatic logic [35:0] expect_out(input int p, input bit in_rst, input int scr,
                                               input int ha, input int hf, input int hsy, input int hb,
                                               input int va, input int vf, input int vsy, input int vb);
        int ht, vt, h, v, hp, vp;
        logic d, hs, vs, lt, ft;
        ht = ha + hf + hsy + hb;
        vt = va + vf + vsy + vb;
        if (in_rst) return {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'(scr)};
        h  = p % ht;
        v  = (p / ht) % vt;
        hp = ((p - SHIFT) % ht);
        vp = ((p - SHIFT) / ht) % vt;
        d  = (h < ha) && (v < va);
        hs = !((hp >= ha + hf) && (hp < ha + hf + hsy));
        vs = !((vp >= va + vf) && (vp < va + vf + vsy));
        lt = (h == ht - 1);
        ft = lt && (v == vt - 1);
        return {10'(h), 10'(v), d, hs, vs, lt, ft, 11'(scr)};
    endfunction

    always @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pd <= 0; ps <= 0; rs <= 1'b1; scr_d <= 0; scr_s <= 0;
        end else begin
            rs <= 1'b0;
            pd <= pd + 1;
            ps <= ps + 1;
            if (((pd + 1) % D_FRAME == 0) && scroll_en) scr_d <= (scr_d + int'(scroll_speed)) % 2048;
            if (((ps + 1) % S_FRAME == 0) && scroll_en) scr_s <= (scr_s + int'(scroll_speed)) % 2048;
        end
    end

    task automatic cmp_vec(input string name, input int p, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s p=%0d: actual h=%0d v=%0d disp/hs/vs/lt/ft=%05b scroll=%0d, required h=%0d v=%0d disp/hs/vs/lt/ft=%05b scroll=%0d",
                     name, p, act[35:26], act[25:16], act[15:11], act[10:0],
                     exp[35:26], exp[25:16], exp[15:11], exp[10:0]);
        end
    endtask

    always @(negedge clk) begin
        cmp_vec("raster_default", pd, {d_haddr, d_vaddr, d_disp, d_hs, d_vs, d_lt, d_ft, d_scroll},
                expect_out(pd, rs, scr_d, DH_A, DH_F, DH_S, DH_B, DV_A, DV_F, DV_S, DV_B));
        cmp_vec("raster_small", ps, {s_haddr, s_vaddr, s_disp, s_hs, s_vs, s_lt, s_ft, s_scroll},
                expect_out(ps, rs, scr_s, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B));
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Returns at the first negedge of a new small-raster frame.
    task automatic step_frame();
        int k = 0;
        @(negedge clk);
        while (!s_ft && k < 4 * S_FRAME) begin
            @(negedge clk);
            k++;
        end
        if (k >= 4 * S_FRAME) timeout("step_frame");
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_haddr"}, int'(d_haddr), 0);
        chk({tag, "_vaddr"}, int'(d_vaddr), 0);
        chk({tag, "_disp"}, int'(d_disp), 0);
        chk({tag, "_hsync"}, int'(d_hs), 1);
        chk({tag, "_vsync"}, int'(d_vs), 1);
        chk({tag, "_ticks"}, int'({d_lt, d_ft}), 0);
        chk({tag, "_scroll_s"}, int'(s_scroll), 0);
    endtask

    initial begin
        int k, disp_n, hs_n, first_hs, tick_n, last_tick, period, vs_n, first_vs_v, first_vs_h, ft_n, sdisp_n;
        sys_rst_n = 1'b1;
        scroll_en = 1'b0;
        scroll_speed = 3'd0;
        #1 sys_rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check_reset_values("rst");

        @(posedge clk);
        #2 sys_rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("first_haddr", int'(d_haddr), 1);
        chk("first_disp", int'(d_disp), 1);

        // two full lines of the full-size raster
        k = 0;
        while (d_haddr != 10'd0 && k < 1000) begin @(negedge clk); k++; end
        if (k >= 1000) timeout("line_start");
        disp_n = 0; hs_n = 0; first_hs = -1; tick_n = 0; last_tick = -1; period = 0;
        for (int i = 0; i < 1600; i++) begin
            if (d_disp) disp_n++;
            if (!d_hs) begin
                hs_n++;
                if (first_hs < 0) first_hs = int'(d_haddr);
            end
            if (d_lt) begin
                tick_n++;
                if (last_tick >= 0) period = i - last_tick;
                last_tick = i;
            end
            @(negedge clk);
        end
        chk("line_disp_clks", disp_n, 1280);
        chk("line_hsync_clks", hs_n, 192);
        chk("hsync_first_haddr", first_hs, 656 + SHIFT);
        chk("line_tick_count", tick_n, 2);
        chk("line_tick_period", period, 800);

        // one full frame of the small raster
        step_frame();
        vs_n = 0; first_vs_v = -1; first_vs_h = -1; ft_n = 0; sdisp_n = 0; hs_n = 0; last_tick = -1; period = 0;
        for (int i = 0; i < 2 * S_FRAME; i++) begin
            if (i < S_FRAME) begin
                if (s_disp) sdisp_n++;
                if (!s_hs) hs_n++;
                if (!s_vs) begin
                    vs_n++;
                    if (first_vs_v < 0) begin first_vs_v = int'(s_vaddr); first_vs_h = int'(s_haddr); end
                end
            end
            if (s_ft) begin
                ft_n++;
                if (last_tick >= 0) period = i - last_tick;
                last_tick = i;
            end
            @(negedge clk);
        end
        chk("small_disp_clks", sdisp_n, 12);
        chk("small_hsync_clks", hs_n, 12);
        chk("small_vsync_clks", vs_n, 8);
        chk("small_vsync_vaddr", first_vs_v, 4);
        chk("small_vsync_haddr", first_vs_h, SHIFT);
        chk("small_frame_ticks", ft_n, 2);
        chk("small_frame_period", period, S_FRAME);

        // scroll accumulation and wrap
        scroll_en = 1'b1;
        scroll_speed = 3'd7;
        for (int i = 0; i < 400 && s_scroll != 11'd2044; i++) step_frame();
        chk("scroll_reach", int'(s_scroll), 2044);
        scroll_speed = 3'd2;
        step_frame();
        chk("scroll_2046", int'(s_scroll), 2046);
        scroll_speed = 3'd3;
        step_frame();
        chk("scroll_wrap", int'(s_scroll), 1);
        step_frame();
        chk("scroll_4", int'(s_scroll), 4);
        scroll_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_frame();
            chk("scroll_hold", int'(s_scroll), 4);
        end
        scroll_en = 1'b1;
        scroll_speed = 3'd3;
        repeat (20) @(negedge clk);
        scroll_speed = 3'd5;
        step_frame();
        chk("scroll_midframe", int'(s_scroll), 9);
        repeat (10) @(negedge clk);
        scroll_speed = 3'd6;
        k = 0;
        while (!s_ft && k < 4 * S_FRAME) begin @(negedge clk); k++; end
        if (k >= 4 * S_FRAME) timeout("frame_tick_wait");
        scroll_speed = 3'd1;
        @(negedge clk);
        chk("scroll_sample_at_wrap", int'(s_scroll), 10);
        scroll_en = 1'b0;

        // asynchronous reset in the middle of a frame
        k = 0;
        while (d_haddr != 10'd300 && k < 1000) begin @(negedge clk); k++; end
        if (k >= 1000) timeout("haddr_300");
        #2 sys_rst_n = 1'b0;
        #1 check_reset_values("midrst");
        chk("midrst_small_haddr", int'(s_haddr), 0);
        @(posedge clk);
        @(posedge clk);
        #2 sys_rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("restart_haddr", int'(d_haddr), 1);
        chk("restart_vaddr", int'(d_vaddr), 0);
        chk("restart_disp", int'(d_disp), 1);

        repeat (100) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
